fc_l2_data_arbiter: RTL and testbench
=====================================

// Module: fc_l2_data_arbiter
// PURPOSE
// - Shares the FC subsystem's single L2 data TCDM master port among N_REQ requesters (core LSU, debug/system bus, DMA-lite).
// - Round-robin arbitration on req/gnt; in-order r_valid responses routed back to the granted requester via an ID FIFO.
// - Sits between the requesters and the l2_data_master bus fields inside fc_subsystem.
// PARAMETERS
// - N_REQ            2   number of requester ports (>=2)
// - MAX_OUTSTANDING  2   max granted-but-unanswered transactions (>=1)
// - ADDR_WIDTH       32  address width
// - DATA_WIDTH       32  data width; BE width = DATA_WIDTH/8
// PORTS
// - clk_i            in   1                   clock
// - rst_ni           in   1                   asynchronous reset, active low
// - slv_req_i        in   N_REQ               request per requester
// - slv_add_i        in   N_REQ*ADDR_WIDTH    address per requester
// - slv_wen_i        in   N_REQ               1=read, 0=write (TCDM polarity)
// - slv_wdata_i      in   N_REQ*DATA_WIDTH    write data
// - slv_be_i         in   N_REQ*DATA_WIDTH/8  byte enables
// - slv_gnt_o        out  N_REQ               grant, one-hot or zero
// - slv_r_valid_o    out  N_REQ               response valid, one-hot or zero
// - slv_r_rdata_o    out  DATA_WIDTH          response data (shared)
// - slv_r_opc_o      out  1                   response error (shared)
// - mst_req_o / mst_add_o / mst_wen_o / mst_wdata_o / mst_be_o  out  to L2 master
// - mst_gnt_i, mst_r_valid_i, mst_r_rdata_i, mst_r_opc_i         in   from L2 master
// - unexp_rsp_o      out  1                   sticky: r_valid arrived with empty ID FIFO
// - stall_cnt_o      out  N_REQ*32            per-requester stall cycles (FC_L2_ARB_PERF_EN only)
// BEHAVIOUR
// - Reset: all outputs 0; rr pointer=0; ID FIFO empty; lock cleared; unexp_rsp_o=0; counters 0.
// - States: IDLE (no lock) / LOCKED (winner presented, not yet granted). Lock register holds winner index.
// - IDLE: if any slv_req_i and FIFO not full -> winner = first active index at or after rr pointer; drive mst_* from winner.
// - Presented-not-granted (mst_req_o & ~mst_gnt_i): enter LOCKED; winner and mst_* fields stay fixed until mst_gnt_i, regardless of other requests.
// - Grant: slv_gnt_o[winner] = mst_gnt_i, combinational, same cycle; push winner into ID FIFO; rr pointer <= winner+1 (wrap at N_REQ); return to IDLE.
// - FIFO full (count==MAX_OUTSTANDING, registered): mst_req_o=0, no grants, even if mst_r_valid_i pops this cycle (no gnt/r_valid comb path).
// - Response: mst_r_valid_i -> slv_r_valid_o[fifo head]=1 same cycle; rdata/opc passed through; pop head. Push and pop in same cycle: count unchanged.
// - mst_r_valid_i with FIFO empty: dropped, unexp_rsp_o set until reset.
// - Requester dropping req while LOCKED is a protocol violation; arbiter keeps presenting latched fields (assertion flags it).
// - Latency: 0 cycles added on req/gnt and on response path.
// - Reset mid-operation: FIFO and lock cleared; late responses after reset set unexp_rsp_o.
// CONFIGURATION
// - FC_L2_ARB_PERF_EN defined: stall_cnt_o[i] increments (saturating at 2^32-1) each cycle slv_req_i[i]=1 & slv_gnt_o[i]=0.
// - Not defined: counter logic absent, stall_cnt_o tied to 0.
// STRUCTURE
// - Package fc_l2_arb_pkg: typedef req_idx_t (clog2(N_REQ) bits), typedef tcdm_req_t struct {add, wen, wdata, be}.
// - Sub-module fc_l2_arb_id_fifo: MAX_OUTSTANDING-deep FIFO of req_idx_t with push/pop/full/empty/count.
// TESTING
// - Single req0 read, mst_gnt_i same cycle, r_valid 2 cycles later rdata=0xDEADBEEF -> slv_gnt_o=01 cycle 0, slv_r_valid_o=01 with 0xDEADBEEF.
// - req0 and req1 held high, gnt every cycle -> grants alternate 01,10,01,10; responses route in grant order.
// - req1 presented, mst_gnt_i low 3 cycles while req0 rises -> mst_add_o stays req1 address; grant goes to req1 on cycle 4.
// - MAX_OUTSTANDING=2, two grants, no responses -> mst_req_o=0 next cycle; one r_valid -> mst_req_o reasserts cycle after pop.
// - mst_r_valid_i with FIFO empty -> no slv_r_valid_o, unexp_rsp_o=1 held; rst_ni low clears it asynchronously.
// - With FC_L2_ARB_PERF_EN: req1 waits 5 cycles behind locked req0 -> stall_cnt_o[1]=5; without macro -> stall_cnt_o=0.

Source files
------------

// File: rtl/fc_l2_arb_pkg.sv
// fc_l2_arb_pkg: shared types and default sizing for the FC L2 data arbiter
package fc_l2_arb_pkg;

    localparam int N_REQ_DEF      = 2;
    localparam int MAX_OUT_DEF    = 2;
    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 32;

    typedef logic [$clog2(N_REQ_DEF)-1:0] req_idx_t;

    typedef struct packed {
        logic [ADDR_WIDTH_DEF-1:0]   add;
        logic                        wen;
        logic [DATA_WIDTH_DEF-1:0]   wdata;
        logic [DATA_WIDTH_DEF/8-1:0] be;
    } tcdm_req_t;

    typedef enum logic {IDLE, LOCKED} arb_state_e;

endpackage

// File: rtl/fc_l2_data_arbiter_if.sv
// fc_l2_data_arbiter_if: TCDM req/gnt + response bundle, N ports wide (N=1 for the L2 master side)
interface fc_l2_data_arbiter_if #(
    parameter int N  = 1,
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [N-1:0]        req;
    logic [N*AW-1:0]     add;
    logic [N-1:0]        wen;
    logic [N*DW-1:0]     wdata;
    logic [N*DW/8-1:0]   be;
    logic [N-1:0]        gnt;
    logic [N-1:0]        r_valid;
    logic [DW-1:0]       r_rdata;
    logic                r_opc;

    modport master (output req, add, wen, wdata, be, input gnt, r_valid, r_rdata, r_opc);
    modport slave  (input req, add, wen, wdata, be, output gnt, r_valid, r_rdata, r_opc);
endinterface

// File: rtl/fc_l2_arb_id_fifo.sv
// fc_l2_arb_id_fifo: in-order FIFO of granted requester indices awaiting their response
module fc_l2_arb_id_fifo
    import fc_l2_arb_pkg::*;
#(
    parameter int DEPTH = MAX_OUT_DEF,
    parameter int W     = $bits(req_idx_t),
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // storage needs no reset: entries are only read while count says they are valid
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;

endmodule

// File: rtl/fc_l2_data_arbiter.sv
// fc_l2_data_arbiter: round-robin share of the FC L2 data master port, responses routed by ID FIFO
// Optional: define FC_L2_ARB_PERF_EN for per-requester saturating stall counters.
module fc_l2_data_arbiter
    import fc_l2_arb_pkg::*;
#(
    parameter int N_REQ           = N_REQ_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUT_DEF,
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    fc_l2_data_arbiter_if.slave      slv,
    fc_l2_data_arbiter_if.master     mst,
    output logic                     unexp_rsp_o,
    output logic [N_REQ*32-1:0]      stall_cnt_o
);

    localparam int IW = $clog2(N_REQ);
    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef logic [IW-1:0] idx_t;

    arb_state_e state, state_nxt;
    idx_t       lock_idx, lock_nxt, rr_ptr, rr_nxt, pick, win, head;
    logic       full, empty, present, granted, pop;
    logic [CW-1:0] fifo_cnt;

    // first requester at or after the rr pointer; scanning backwards lets the nearest one win
    always_comb begin
        pick = rr_ptr;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (slv.req[idx_t'((int'(rr_ptr) + k) % N_REQ)]) pick = idx_t'((int'(rr_ptr) + k) % N_REQ);
        end
    end

    assign win     = (state == LOCKED) ? lock_idx : pick;
    // full is registered occupancy, so a same-cycle response never opens a grant path
    assign present = ~full & ((state == LOCKED) | (|slv.req));
    assign granted = present & mst.gnt[0];
    assign pop     = mst.r_valid[0] & ~empty;

    assign mst.req   = present;
    assign mst.add   = present ? slv.add[int'(win)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign mst.wen   = present ? slv.wen[win] : 1'b0;
    assign mst.wdata = present ? slv.wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign mst.be    = present ? slv.be[int'(win)*BW +: BW] : '0;

    assign slv.gnt     = granted ? N_REQ'(1) << win : '0;
    assign slv.r_valid = pop ? N_REQ'(1) << head : '0;
    assign slv.r_rdata = mst.r_rdata;
    assign slv.r_opc   = mst.r_opc;

    // arbitration state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            lock_idx <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            lock_idx <= lock_nxt;
            rr_ptr   <= rr_nxt;
        end
    end

    // a grant releases the lock and advances rr; an unanswered presentation freezes the winner
    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_idx;
        rr_nxt    = rr_ptr;
        if (granted) begin
            state_nxt = IDLE;
            rr_nxt    = (win == idx_t'(N_REQ - 1)) ? '0 : win + 1'b1;
        end else if (present) begin
            state_nxt = LOCKED;
            lock_nxt  = win;
        end
    end

    fc_l2_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .W     (IW)
    ) u_id_fifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (granted),
        .pop   (pop),
        .wdata (win),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_cnt)
    );

    // a response with nothing outstanding is dropped and remembered until reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) unexp_rsp_o <= 1'b0;
        else if (mst.r_valid[0] & empty) unexp_rsp_o <= 1'b1;
    end

`ifdef FC_L2_ARB_PERF_EN
    logic [31:0] stall_cnt [N_REQ];
    for (genvar i = 0; i < N_REQ; i++) begin : g_stall
        // cycles requester i spends requesting without a grant, saturating
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) stall_cnt[i] <= '0;
            else if (slv.req[i] & ~slv.gnt[i] & ~&stall_cnt[i]) stall_cnt[i] <= stall_cnt[i] + 1'b1;
        end
        assign stall_cnt_o[i*32 +: 32] = stall_cnt[i];
    end
`else
    assign stall_cnt_o = '0;
`endif

    a_lock_hold: assert property (@(posedge clk_i) disable iff (!rst_ni) state == LOCKED |-> slv.req[lock_idx]);
    a_fifo_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) int'(fifo_cnt) <= MAX_OUTSTANDING);

endmodule

// File: tb/tb_fc_l2_data_arbiter.sv
// tb_fc_l2_data_arbiter: directed scenarios plus random traffic against a queue-based reference model
module tb_fc_l2_data_arbiter;

    localparam int N  = 2;
    localparam int M  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
`ifdef FC_L2_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            unexp;
    logic [N*32-1:0] stall;

    fc_l2_data_arbiter_if #(.N(N), .AW(AW), .DW(DW)) slv ();
    fc_l2_data_arbiter_if #(.N(1), .AW(AW), .DW(DW)) mst ();

    fc_l2_data_arbiter #(
        .N_REQ          (N),
        .MAX_OUTSTANDING(M),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .slv        (slv),
        .mst        (mst),
        .unexp_rsp_o(unexp),
        .stall_cnt_o(stall)
    );

    always #5 clk = ~clk;

    logic          r_req   [N];
    logic [AW-1:0] r_add   [N];
    logic          r_wen   [N];
    logic [DW-1:0] r_wdata [N];
    logic [BW-1:0] r_be    [N];
    logic          m_gnt, rsp_valid, rsp_opc;
    logic [DW-1:0] rsp_rdata;

    int              q[$];
    int              rr, lk, win;
    bit              lk_v, m_unexp, pres, popd, stray;
    longint unsigned m_stall [N];
    logic [N-1:0]    eg, ev, req_snap;
    int              n_cmp = 0;
    int              n_err = 0;

    function automatic logic [N-1:0] onehot(int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            slv.req[i]              = r_req[i];
            slv.add[i*AW +: AW]     = r_add[i];
            slv.wen[i]              = r_wen[i];
            slv.wdata[i*DW +: DW]   = r_wdata[i];
            slv.be[i*BW +: BW]      = r_be[i];
        end
        mst.gnt[0]     = m_gnt;
        mst.r_valid[0] = rsp_valid;
        mst.r_rdata    = rsp_rdata;
        mst.r_opc      = rsp_opc;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < N; i++) begin
            r_req[i] = 1'b0; r_add[i] = '0; r_wen[i] = 1'b0; r_wdata[i] = '0; r_be[i] = '0;
        end
        m_gnt = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; rsp_opc = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        rr = 0; lk = 0; lk_v = 1'b0; m_unexp = 1'b0;
        for (int i = 0; i < N; i++) m_stall[i] = 0;
    endtask

    // expectations from the arbitration rules, checked mid-cycle
    task automatic sample();
        drive();
        @(negedge clk);
        for (int i = 0; i < N; i++) req_snap[i] = r_req[i];
        win = rr;
        if (lk_v) win = lk;
        else begin
            for (int k = 0; k < N; k++) begin
                if (r_req[(rr + k) % N]) begin
                    win = (rr + k) % N;
                    break;
                end
            end
        end
        pres  = (q.size() < M) && (lk_v || (req_snap != '0));
        eg    = (pres && m_gnt) ? onehot(win) : '0;
        popd  = rsp_valid && (q.size() > 0);
        stray = rsp_valid && (q.size() == 0);
        ev    = popd ? onehot(q[0]) : '0;
        chk("mst_req", 64'(mst.req), 64'(pres));
        chk("slv_gnt", 64'(slv.gnt), 64'(eg));
        chk("slv_r_valid", 64'(slv.r_valid), 64'(ev));
        chk("unexp_rsp", 64'(unexp), 64'(m_unexp));
        if (pres) begin
            chk("mst_add", 64'(mst.add), 64'(r_add[win]));
            chk("mst_wen", 64'(mst.wen), 64'(r_wen[win]));
            chk("mst_wdata", 64'(mst.wdata), 64'(r_wdata[win]));
            chk("mst_be", 64'(mst.be), 64'(r_be[win]));
        end
        if (popd) begin
            chk("r_rdata", 64'(slv.r_rdata), 64'(rsp_rdata));
            chk("r_opc", 64'(slv.r_opc), 64'(rsp_opc));
        end
        for (int i = 0; i < N; i++) chk($sformatf("stall_cnt[%0d]", i), 64'(stall[i*32 +: 32]), PERF ? 64'(m_stall[i]) : 64'd0);
    endtask

    task automatic advance();
        @(posedge clk);
        if (popd) void'(q.pop_front());
        if (stray) m_unexp = 1'b1;
        if (eg != '0) begin
            q.push_back(win);
            rr   = (win + 1) % N;
            lk_v = 1'b0;
        end else if (pres) begin
            lk_v = 1'b1;
            lk   = win;
        end
        for (int i = 0; i < N; i++) if (req_snap[i] && !eg[i] && m_stall[i] < 64'hFFFF_FFFF) m_stall[i]++;
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_stim();
        drive();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_stim();
        model_reset();
        drive();
        #3;
        chk("rst_mst_req", 64'(mst.req), 64'd0);
        chk("rst_gnt", 64'(slv.gnt), 64'd0);
        chk("rst_r_valid", 64'(slv.r_valid), 64'd0);
        chk("rst_unexp", 64'(unexp), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single read from requester 0, response two cycles later
        r_req[0] = 1'b1; r_add[0] = 32'h0000_1000; r_wen[0] = 1'b1; r_be[0] = 4'hF; m_gnt = 1'b1;
        sample();
        chk("t1_gnt", 64'(slv.gnt), 64'h1);
        advance();
        r_req[0] = 1'b0; m_gnt = 1'b0;
        step();
        rsp_valid = 1'b1; rsp_rdata = 32'hDEAD_BEEF;
        sample();
        chk("t1_r_valid", 64'(slv.r_valid), 64'h1);
        chk("t1_rdata", 64'(slv.r_rdata), 64'hDEAD_BEEF);
        advance();

        // both requesting, grant every cycle: alternation and in-order routing
        do_reset();
        r_req[0] = 1'b1; r_add[0] = 32'h0000_0A00; r_wen[0] = 1'b0; r_wdata[0] = 32'h1111_0000; r_be[0] = 4'h3;
        r_req[1] = 1'b1; r_add[1] = 32'h0000_0B00; r_wen[1] = 1'b1; r_wdata[1] = 32'h2222_0000; r_be[1] = 4'hC;
        m_gnt = 1'b1;
        for (int c = 0; c < 4; c++) begin
            rsp_valid = (c > 0);
            rsp_rdata = 32'h0000_A000 + 32'(c);
            sample();
            chk("t2_gnt", 64'(slv.gnt), (c % 2 == 1) ? 64'h2 : 64'h1);
            if (c > 0) chk("t2_r_valid", 64'(slv.r_valid), (c % 2 == 1) ? 64'h1 : 64'h2);
            advance();
        end

        // requester 1 presented and held off; requester 0 arriving must not steal the slot
        do_reset();
        r_req[1] = 1'b1; r_add[1] = 32'h0000_00A1; r_wen[1] = 1'b1; r_be[1] = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                r_req[0] = 1'b1; r_add[0] = 32'h0000_00A0;
            end
            m_gnt = (c == 3);
            sample();
            chk("t3_mst_add", 64'(mst.add), 64'h0000_00A1);
            chk("t3_gnt", 64'(slv.gnt), (c == 3) ? 64'h2 : 64'h0);
            advance();
        end

        // outstanding limit: two grants fill the FIFO, a pop reopens it one cycle later
        do_reset();
        r_req[0] = 1'b1; r_add[0] = 32'h0000_0100;
        r_req[1] = 1'b1; r_add[1] = 32'h0000_0200;
        m_gnt = 1'b1;
        for (int c = 0; c < 5; c++) begin
            rsp_valid = (c == 3);
            sample();
            chk("t4_mst_req", 64'(mst.req), (c == 2 || c == 3) ? 64'h0 : 64'h1);
            advance();
        end

        // requester 1 stalls behind a locked requester 0
        do_reset();
        r_req[0] = 1'b1; r_add[0] = 32'h0000_0300;
        r_req[1] = 1'b1; r_add[1] = 32'h0000_0400;
        repeat (5) step();
        sample();
        chk("t6_stall1", 64'(stall[63:32]), PERF ? 64'd5 : 64'd0);
        advance();

        // stray response: dropped, sticky flag, async clear, set again by a late response
        do_reset();
        rsp_valid = 1'b1; rsp_rdata = 32'h0BAD_0BAD;
        sample();
        chk("t7_no_r_valid", 64'(slv.r_valid), 64'h0);
        advance();
        rsp_valid = 1'b0;
        step();
        sample();
        chk("t7_unexp_held", 64'(unexp), 64'h1);
        advance();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_async_clear", 64'(unexp), 64'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rsp_valid = 1'b1;
        step();
        rsp_valid = 1'b0;
        sample();
        chk("t7_late_unexp", 64'(unexp), 64'h1);
        advance();

        // random traffic; a requester holds its fields until granted
        do_reset();
        repeat (400) begin
            sample();
            advance();
            for (int i = 0; i < N; i++) begin
                if (!r_req[i] || eg[i]) begin
                    r_req[i]   = ($urandom_range(0, 2) != 0);
                    r_add[i]   = $urandom;
                    r_wen[i]   = 1'($urandom_range(0, 1));
                    r_wdata[i] = $urandom;
                    r_be[i]    = BW'($urandom_range(0, 15));
                end
            end
            m_gnt     = ($urandom_range(0, 3) != 0);
            rsp_valid = (q.size() > 0) && ($urandom_range(0, 1) == 1);
            rsp_rdata = $urandom;
            rsp_opc   = 1'($urandom_range(0, 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
